scnn_compressor: RTL and testbench

Sparse encoder feeding the SCNN processing elements. Accepts a dense stream of 16-bit activations or weights one element per cycle. Drops zeros and packs the nonzero values with their original dense positions into the compressed value/index arrays and nonzero count that the PE consumes. Sits between the activation/weight staging buffers and each PE; one instance per operand stream.

---
 rtl/scnn_compressor.sv | 156 +++++++++++++++
 tb/tb_scnn_compressor.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scnn_compressor.sv
// -----------------------------------------------------------------------------
// scnn_compressor
//   Sparse encoder in front of an SCNN processing element. Takes a dense
//   stream of elements, one per cycle, and keeps only the nonzero values. Each
//   kept value is stored with its dense position in a compressed value/index
//   array. A finished frame is held stable until the PE takes it.
//
// Ports
//   clk, rst      : clock; asynchronous active-high reset
//   in_valid      : dense element present on in_data
//   in_ready      : element accepted this cycle (high while collecting)
//   in_data       : dense element, two's complement
//   in_last       : final element of the frame
//   comp_values   : packed nonzero values, entry 0 first, unused entries 0
//   comp_indices  : dense position of each packed value, unused entries 0
//   num_nz        : number of valid packed entries
//   frame_len     : accepted dense elements in the frame (saturating)
//   out_valid     : compressed frame complete and stable
//   out_ready     : PE has captured the frame
//   overflow      : frame had more than MAX_NZ nonzeros or ran out of positions
//
// MAX_NZ must be a multiple of 4 and smaller than 2**IDX_W. The PE fetches
// entries in groups of 4, so the zero padding in unused entries yields zero
// products.
// -----------------------------------------------------------------------------
module scnn_compressor #(
  parameter int MAX_NZ = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  input  logic                           in_last,
  output logic [MAX_NZ-1:0][DATA_W-1:0]  comp_values,
  output logic [MAX_NZ-1:0][IDX_W-1:0]   comp_indices,
  output logic [IDX_W-1:0]               num_nz,
  output logic [IDX_W-1:0]               frame_len,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           overflow
);

  localparam int CNT_W = $clog2(MAX_NZ + 1);
  localparam logic [IDX_W-1:0] POS_MAX = {IDX_W{1'b1}};

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic [MAX_NZ-1:0][DATA_W-1:0]  r_values;
  logic [MAX_NZ-1:0][IDX_W-1:0]   r_indices;
  logic [CNT_W-1:0]               r_nz_cnt;
  // The position counter doubles as the saturating frame length: both equal
  // min(accepted beats, 2**IDX_W-1).
  logic [IDX_W-1:0]               r_pos;
  logic                           r_overflow;

  logic w_accept;
  logic w_release;
  logic w_nonzero;
  logic w_has_room;
  logic w_pos_sat;

  assign w_accept   = in_valid && (r_state == COLLECT);
  assign w_release  = out_ready && (r_state == HOLD);
  assign w_nonzero  = (in_data != {DATA_W{1'b0}});
  assign w_has_room = (r_nz_cnt < CNT_W'(MAX_NZ));
  assign w_pos_sat  = (r_pos == POS_MAX);

  // Handshake outputs decode straight from the state register.
  assign in_ready     = (r_state == COLLECT);
  assign out_valid    = (r_state == HOLD);
  assign comp_values  = r_values;
  assign comp_indices = r_indices;
  assign num_nz       = IDX_W'(r_nz_cnt);
  assign frame_len    = r_pos;
  assign overflow     = r_overflow;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= COLLECT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: the last accepted beat closes the frame, and the PE
  // handshake reopens collection.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      COLLECT: begin
        if (w_accept && in_last) begin
          w_next_state = HOLD;
        end else begin
          w_next_state = COLLECT;
        end
      end
      HOLD: begin
        if (w_release) begin
          w_next_state = COLLECT;
        end else begin
          w_next_state = HOLD;
        end
      end
      default: w_next_state = COLLECT;
    endcase
  end

  // Compressed arrays, counters and sticky overflow. The release handshake
  // wipes everything, so unused entries are always zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_values   <= '0;
      r_indices  <= '0;
      r_nz_cnt   <= '0;
      r_pos      <= '0;
      r_overflow <= 1'b0;
    end else if (w_release) begin
      r_values   <= '0;
      r_indices  <= '0;
      r_nz_cnt   <= '0;
      r_pos      <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      if (w_nonzero && w_has_room) begin
        // The slot is selected by comparison. This keeps the write index
        // within the array range.
        for (int i = 0; i < MAX_NZ; i++) begin
          if (CNT_W'(i) == r_nz_cnt) begin
            r_values[i]  <= in_data;
            r_indices[i] <= r_pos;
          end
        end
        r_nz_cnt <= r_nz_cnt + CNT_W'(1);
      end
      // A nonzero element that arrives when the array is full is dropped.
      // If the position counter is already at its top value, the position
      // holds and later elements reuse it. Either case flags the frame.
      if ((w_nonzero && !w_has_room) || w_pos_sat) begin
        r_overflow <= 1'b1;
      end
      if (!w_pos_sat) begin
        r_pos <= r_pos + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_scnn_compressor.sv
// -----------------------------------------------------------------------------
// tb_scnn_compressor
//   Scoreboard bench for scnn_compressor. The stimulus process builds dense
//   frames, computes the expected compressed frame from the frame contents,
//   and queues it. A monitor process on the falling edge pops and compares
//   whenever the DUT presents a frame. It also checks the reset state, the
//   cleared state after each handshake, HOLD stability, and last-beat latency.
// -----------------------------------------------------------------------------
module tb_scnn_compressor;

  localparam int MAX_NZ = 16;
  localparam int DATA_W = 16;
  localparam int IDX_W  = 8;
  localparam int POS_TOP = (1 << IDX_W) - 1;

  typedef struct packed {
    logic [MAX_NZ-1:0][DATA_W-1:0] vals;
    logic [MAX_NZ-1:0][IDX_W-1:0]  idx;
    logic [IDX_W-1:0]              nnz;
    logic [IDX_W-1:0]              flen;
    logic                          ovf;
  } exp_t;

  logic                          clk;
  logic                          rst;
  logic                          in_valid;
  logic                          in_ready;
  logic [DATA_W-1:0]             in_data;
  logic                          in_last;
  logic [MAX_NZ-1:0][DATA_W-1:0] comp_values;
  logic [MAX_NZ-1:0][IDX_W-1:0]  comp_indices;
  logic [IDX_W-1:0]              num_nz;
  logic [IDX_W-1:0]              frame_len;
  logic                          out_valid;
  logic                          out_ready;
  logic                          overflow;

  exp_t              sb[$];
  logic [DATA_W-1:0] frame[$];
  int                stall_cycles;
  bit                stim_done;

  int   vectors;
  int   miscompares;

  scnn_compressor #(.MAX_NZ(MAX_NZ), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .comp_values  (comp_values),
    .comp_indices (comp_indices),
    .num_nz       (num_nz),
    .frame_len    (frame_len),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: filter out zeros and keep the first MAX_NZ nonzeros with
  // their dense positions. Positions stop at the top index.
  function automatic exp_t model(input int n, input logic [DATA_W-1:0] d[$]);
    exp_t e;
    int   nz;
    int   p;
    e  = '0;
    nz = 0;
    for (int k = 0; k < n; k++) begin
      p = (k < POS_TOP) ? k : POS_TOP;
      if (d[k] != 16'd0) begin
        if (nz < MAX_NZ) begin
          e.vals[nz] = d[k];
          e.idx[nz]  = IDX_W'(p);
        end
        nz++;
      end
    end
    e.nnz  = IDX_W'((nz < MAX_NZ) ? nz : MAX_NZ);
    e.flen = IDX_W'((n < POS_TOP) ? n : POS_TOP);
    e.ovf  = (nz > MAX_NZ) || (n > POS_TOP);
    return e;
  endfunction

  // Comparison helper: counts and reports.
  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  // out_ready: random, forced low for the first stall_cycles cycles of each HOLD.
  int ord_cnt;
  always @(posedge clk) begin
    #1;
    if (rst || !out_valid) begin
      ord_cnt   = 0;
      out_ready = ($urandom_range(0, 1) == 0);
    end else begin
      ord_cnt++;
      out_ready = (ord_cnt > stall_cycles) && ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor / scoreboard.
  exp_t cur;
  bit   have_cur;
  bit   post_hs;
  bit   pend_last;
  int   idle_cycles;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_in_ready",  256'(in_ready),     256'(1));
      check("rst_out_valid", 256'(out_valid),    256'(0));
      check("rst_overflow",  256'(overflow),     256'(0));
      check("rst_num_nz",    256'(num_nz),       256'(0));
      check("rst_frame_len", 256'(frame_len),    256'(0));
      check("rst_values",    256'(comp_values),  256'(0));
      check("rst_indices",   256'(comp_indices), 256'(0));
      have_cur    = 1'b0;
      post_hs     = 1'b0;
      pend_last   = 1'b0;
      idle_cycles = 0;
    end else begin
      if (pend_last) begin
        check("latency_out_valid", 256'(out_valid), 256'(1));
        pend_last = 1'b0;
      end
      if (post_hs) begin
        check("clr_out_valid", 256'(out_valid),    256'(0));
        check("clr_in_ready",  256'(in_ready),     256'(1));
        check("clr_num_nz",    256'(num_nz),       256'(0));
        check("clr_frame_len", 256'(frame_len),    256'(0));
        check("clr_overflow",  256'(overflow),     256'(0));
        check("clr_values",    256'(comp_values),  256'(0));
        check("clr_indices",   256'(comp_indices), 256'(0));
        post_hs = 1'b0;
      end
      if (out_valid) begin
        if (!have_cur) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame: got out_valid=1 expected no frame pending");
            cur = '0;
          end else begin
            cur = sb.pop_front();
          end
          have_cur = 1'b1;
        end
        check("hold_in_ready", 256'(in_ready),     256'(0));
        check("values",        256'(comp_values),  256'(cur.vals));
        check("indices",       256'(comp_indices), 256'(cur.idx));
        check("num_nz",        256'(num_nz),       256'(cur.nnz));
        check("frame_len",     256'(frame_len),    256'(cur.flen));
        check("overflow",      256'(overflow),     256'(cur.ovf));
        if (out_ready) begin
          have_cur = 1'b0;
          post_hs  = 1'b1;
        end
      end
      if (in_valid && in_ready && in_last) begin
        pend_last = 1'b1;
      end
      if ((in_valid && in_ready) || (out_valid && out_ready)) begin
        idle_cycles = 0;
      end else begin
        idle_cycles++;
      end
      if (idle_cycles > 500) begin
        vectors++;
        miscompares++;
        $display("FAIL watchdog: got no progress for %0d cycles expected < 500", idle_cycles);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
      if (stim_done && sb.size() == 0 && !out_valid && !post_hs) begin
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    end
  end

  // Drive the current frame. A complete frame queues its expected result and
  // ends with in_last. An incomplete frame is a prefix that a reset interrupts.
  task automatic drive_frame(input bit complete);
    int n;
    n = frame.size();
    if (complete) begin
      sb.push_back(model(n, frame));
    end
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1;
      in_data  = frame[k];
      in_last  = complete && (k == n - 1);
      @(negedge clk);
      while (!in_ready) @(negedge clk);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 16'd0;
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_nz();
    logic [DATA_W-1:0] v;
    v = DATA_W'($urandom);
    if (v == 16'd0) v = 16'd1;
    return v;
  endfunction

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_data      = 16'd0;
    in_last      = 1'b0;
    stall_cycles = 0;
    stim_done    = 1'b0;
    vectors      = 0;
    miscompares  = 0;
    idle(3);
    rst = 1'b0;
    idle(2);

    // Mixed frame: values 5,-3,7,2 at positions 1,4,5,7.
    frame = '{16'd0, 16'd5, 16'd0, 16'd0, 16'hFFFD, 16'd7, 16'd0, 16'd2};
    drive_frame(1'b1);
    idle(2);

    // All-zero frame of 10 elements.
    frame.delete();
    for (int i = 0; i < 10; i++) frame.push_back(16'd0);
    drive_frame(1'b1);
    idle(1);

    // 20 nonzeros: only the first 16 are kept, and overflow is set.
    frame.delete();
    for (int i = 1; i <= 20; i++) frame.push_back(DATA_W'(i));
    drive_frame(1'b1);

    // Exactly MAX_NZ nonzeros, the last one on the last beat: no overflow.
    frame.delete();
    for (int i = 0; i < 4; i++) frame.push_back(16'd0);
    for (int i = 0; i < 16; i++) frame.push_back(DATA_W'(100 + i));
    drive_frame(1'b1);

    // Long stall with the next frame's first beat waiting on in_valid.
    stall_cycles = 5;
    frame = '{16'd11, 16'd0, 16'd22};
    drive_frame(1'b1);
    frame = '{16'd0, 16'd33};
    drive_frame(1'b1);
    stall_cycles = 0;

    // Back-to-back frames with no residue between them.
    frame = '{16'd3, 16'd0, 16'd4};
    drive_frame(1'b1);
    frame = '{16'd0, 16'd0, 16'd9};
    drive_frame(1'b1);
    idle(3);

    // Reset after three nonzeros mid-frame.
    frame = '{16'd1, 16'd2, 16'd3};
    drive_frame(1'b0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    frame = '{16'd0, 16'd8, 16'd0, 16'd6};
    drive_frame(1'b1);

    // Frame longer than the index space: positions saturate, and overflow is set.
    frame.delete();
    for (int i = 0; i < 260; i++)
      frame.push_back(($urandom_range(0, 31) == 0) ? rand_nz() : 16'd0);
    drive_frame(1'b1);

    // Randomised frames of varying length and density.
    for (int f = 0; f < 30; f++) begin
      int n;
      int dens;
      n    = $urandom_range(1, 40);
      dens = $urandom_range(0, 4);
      frame.delete();
      for (int k = 0; k < n; k++)
        frame.push_back(($urandom_range(0, 3) < dens) ? rand_nz() : 16'd0);
      drive_frame(1'b1);
      idle($urandom_range(0, 2));
    end

    stim_done = 1'b1;
  end

endmodule
